sn76489_bus_decoder: RTL and testbench

SN76489_BUS_DECODER -- requirements
Module: sn76489_bus_decoder

---
 rtl/sn76489_bus_decoder.sv | 98 +++++++++
 tb/tb_sn76489_bus_decoder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sn76489_bus_decoder.sv
// sn76489_bus_decoder: decodes SN76489 host command bytes into tone, attenuation and noise registers.
// Optional busy window with write rejection is enabled by defining SN76489_BUS_DECODER_READY_EN.
module sn76489_bus_decoder #(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        wr,
    output logic        ready,
    output logic        drop,
    output logic [15:0] attn,
    output logic [29:0] tone_freq,
    output logic [2:0]  noise_ctrl,
    output logic        noise_reset
);
    logic [1:0]       latch_ch;
    logic             latch_vol;
    logic [3:0][3:0]  attn_r;
    logic [2:0][9:0]  tone_r;
    logic             accept;
    logic             is_latch;
    logic [1:0]       ch;
    logic             vol;

    // a latch byte names its own target; a data byte reuses the stored latch
    always_comb begin
        is_latch = data[7];
        ch       = is_latch ? data[6:5] : latch_ch;
        vol      = is_latch ? data[4] : latch_vol;
    end

`ifdef SN76489_BUS_DECODER_READY_EN
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state, state_next;
    logic [7:0] cnt;

    // state register, busy down-counter and reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= wr && state == BUSY;
            cnt   <= accept ? 8'(READY_CYCLES - 1) : (state == BUSY && cnt != 0 ? cnt - 1'b1 : cnt);
        end
    end

    // leave IDLE on any write, return once the counter has run down
    always_comb state_next = state == IDLE ? (wr ? BUSY : IDLE) : (cnt == 0 ? IDLE : BUSY);

    // ready reflects the registered state directly
    always_comb ready = state == IDLE;

    assign accept = wr && ready;
`else
    assign ready  = 1'b1;
    assign drop   = 1'b0;
    assign accept = wr;
`endif

    // apply accepted writes; a noise-register write also requests an LFSR reload
    always_ff @(posedge clk) begin
        if (reset) begin
            attn_r      <= '1;
            tone_r      <= '0;
            noise_ctrl  <= '0;
            noise_reset <= 1'b0;
            latch_ch    <= '0;
            latch_vol   <= 1'b0;
        end else begin
            noise_reset <= accept && !vol && ch == 2'd3;
            if (accept) begin
                if (is_latch) begin
                    latch_ch  <= data[6:5];
                    latch_vol <= data[4];
                end
                if (vol)
                    attn_r[ch] <= data[3:0];
                else if (ch == 2'd3)
                    noise_ctrl <= data[2:0];
                else
                    for (int i = 0; i < 3; i++)
                        if (ch == 2'(i)) begin
                            if (is_latch)
                                tone_r[i][3:0] <= data[3:0];
                            else
                                tone_r[i][9:4] <= data[5:0];
                        end
            end
        end
    end

    assign attn      = attn_r;
    assign tone_freq = tone_r;
endmodule

// File: tb/tb_sn76489_bus_decoder.sv
// tb_sn76489_bus_decoder: directed scoreboard bench; busy-window checks run when SN76489_BUS_DECODER_READY_EN is defined.
module tb_sn76489_bus_decoder;
    localparam int RC = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        wr = 1'b0;
    logic        ready, drop, noise_reset;
    logic [15:0] attn;
    logic [29:0] tone_freq;
    logic [2:0]  noise_ctrl;

    sn76489_bus_decoder #(.READY_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .data(data), .wr(wr),
        .ready(ready), .drop(drop), .attn(attn), .tone_freq(tone_freq),
        .noise_ctrl(noise_ctrl), .noise_reset(noise_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          cyc;
        logic [15:0] attn;
        logic [29:0] tone;
        logic [2:0]  nc;
        logic        nr;
        logic        rdy;
        logic        drp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [15:0] e_attn = 16'hFFFF;
    logic [29:0] e_tone = '0;
    logic [2:0]  e_nc = '0;
    logic        e_nr = 1'b0;
    logic        e_rdy = 1'b1;
    logic        e_drp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every expectation whose clock edge has passed
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (attn !== e.attn || tone_freq !== e.tone || noise_ctrl !== e.nc ||
                noise_reset !== e.nr || ready !== e.rdy || drop !== e.drp) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got attn=%h tone=%h nc=%b nr=%b rdy=%b drop=%b want attn=%h tone=%h nc=%b nr=%b rdy=%b drop=%b",
                         e.nm, cyc, attn, tone_freq, noise_ctrl, noise_reset, ready, drop,
                         e.attn, e.tone, e.nc, e.nr, e.rdy, e.drp);
            end
        end
    end

    task automatic step(input string nm, input logic w, input logic [7:0] d, input logic rst);
        reset = rst;
        wr    = w;
        data  = d;
        q.push_back('{nm, cyc + 1, e_attn, e_tone, e_nc, e_nr, e_rdy, e_drp});
        e_nr  = 1'b0;
        e_drp = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_exp();
        e_attn = 16'hFFFF; e_tone = '0; e_nc = '0; e_rdy = 1'b1;
    endtask

    task automatic wr_ok(input string nm, input logic [7:0] d);
`ifdef SN76489_BUS_DECODER_READY_EN
        e_rdy = 1'b0;
`endif
        step(nm, 1'b1, d, 1'b0);
`ifdef SN76489_BUS_DECODER_READY_EN
        for (int i = 1; i < RC; i++) step("busy_wait", 1'b0, 8'h00, 1'b0);
        e_rdy = 1'b1;
`endif
    endtask

    initial begin
        @(negedge clk);
        reset_exp();
        step("reset_ignores_wr", 1'b1, 8'hF0, 1'b1);
        e_tone = 30'h010;            wr_ok("data_before_latch", 8'h41);
        e_tone = 30'h020;            wr_ok("data_before_latch2", 8'h02);
        reset_exp();                 step("reset2", 1'b0, 8'h00, 1'b1);
        e_tone = 30'h00E;            wr_ok("tone_latch", 8'h8E);
        e_tone = 30'h0FE;            wr_ok("tone_data", 8'h0F);
        e_attn = 16'hF5FF;           wr_ok("vol_latch", 8'hD5);
        e_attn = 16'hF3FF;           wr_ok("vol_data", 8'h03);
        e_attn = 16'hFCFF;           wr_ok("vol_d6_ignored", 8'h4C);
        e_nc = 3'b101; e_nr = 1'b1;  wr_ok("noise_latch", 8'hE5);
        step("noise_idle", 1'b0, 8'h00, 1'b0);
        e_nc = 3'b110; e_nr = 1'b1;  wr_ok("noise_data", 8'h06);
        e_nr = 1'b1;                 wr_ok("noise_same", 8'h06);
        step("noise_idle2", 1'b0, 8'h00, 1'b0);
        e_attn = 16'h2CFF;           wr_ok("noise_vol", 8'hF2);
        e_attn = 16'h9CFF;           wr_ok("noise_vol_data", 8'h09);
        e_tone = 30'h0000CFE;        wr_ok("tone1_latch", 8'hA3);
        e_tone = 30'h00FCCFE;        wr_ok("tone1_data", 8'h3F);
        e_tone = 30'h07FCCFE;        wr_ok("tone2_latch", 8'hC7);
        reset_exp();                 step("reset3", 1'b0, 8'h00, 1'b1);
`ifdef SN76489_BUS_DECODER_READY_EN
        e_rdy = 1'b0; e_attn = 16'hFFFA; step("busy_accept", 1'b1, 8'h9A, 1'b0);
        e_drp = 1'b1;                    step("busy_reject", 1'b1, 8'hB0, 1'b0);
        for (int i = 2; i < RC; i++)     step("busy_hold", 1'b0, 8'h00, 1'b0);
        e_rdy = 1'b1;                    step("ready_after_32", 1'b0, 8'h00, 1'b0);
        e_rdy = 1'b0; e_attn = 16'hFFFB; step("acc2", 1'b1, 8'h9B, 1'b0);
        e_drp = 1'b1;                    step("rej_a", 1'b1, 8'hB0, 1'b0);
        e_drp = 1'b1;                    step("rej_b", 1'b1, 8'hB1, 1'b0);
        for (int i = 3; i < RC; i++)     step("busy_hold2", 1'b0, 8'h00, 1'b0);
        e_rdy = 1'b1;                    step("ready_after_rej", 1'b0, 8'h00, 1'b0);
        e_rdy = 1'b0; e_attn = 16'hFFF6; step("acc3", 1'b1, 8'h96, 1'b0);
        for (int i = 1; i < 5; i++)      step("busy_pre_reset", 1'b0, 8'h00, 1'b0);
        reset_exp();                     step("reset_mid_busy", 1'b1, 8'hF0, 1'b1);
        e_tone = 30'h010;                wr_ok("post_reset_data", 8'h41);
`else
        e_attn = 16'hFFFA;           step("b2b_a", 1'b1, 8'h9A, 1'b0);
        e_attn = 16'hFF0A;           step("b2b_b", 1'b1, 8'hB0, 1'b0);
`endif
        step("final_idle", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
